// File: rtl/memory_stage.sv
// Memory stage of the 16-bit pipeline: drives data memory through a req/ready handshake,
// stalls the pipe on wait states and registers the write-back payload.
module memory_stage #(
   parameter int MAX_WAIT = 255,
   parameter int WAIT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [15:0] alu_result,
   input  logic [15:0] store_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic [3:0]  dst_reg,
   input  logic        halt,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        mem_stall,
   output logic        wb_valid,
   output logic [15:0] wb_data,
   output logic [3:0]  wb_dst,
   output logic        wb_reg_write,
   output logic        wb_halt,
   output logic        mem_error
);
   // state | meaning
   // IDLE  | accepting from EX/MEM; zero-wait accesses and ALU ops pass straight through
   // BUSY  | access in wait states; request driven from latched copies
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

   state_t            state_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic [15:0]       alu_q, wdata_q;
   logic              we_q, rd_q, rw_q, halt_q;
   logic [3:0]        dst_q;
   logic              wb_valid_q, wb_reg_write_q, wb_halt_q, mem_error_q;
   logic [15:0]       wb_data_q;
   logic [3:0]        wb_dst_q;

   logic        memop, done;
   logic [15:0] cur_alu, cur_wdata, wb_data_d;
   logic        cur_we, cur_rd, cur_rw, cur_halt;
   logic [3:0]  cur_dst;

   always_comb begin
      memop = ex_valid & (mem_read | mem_write);
      if (state_q == BUSY) begin
         cur_alu   = alu_q;
         cur_wdata = wdata_q;
         cur_we    = we_q;
         cur_rd    = rd_q;
         cur_rw    = rw_q;
         cur_dst   = dst_q;
         cur_halt  = halt_q;
         dmem_req  = 1'b1;
         mem_stall = ~dmem_ready;
         done      = dmem_ready;
      end else begin
         cur_alu   = alu_result;
         cur_wdata = store_data;
         cur_we    = mem_write;
         // a read+write combination is treated as a write
         cur_rd    = mem_read & ~mem_write;
         cur_rw    = reg_write;
         cur_dst   = dst_reg;
         cur_halt  = halt;
         dmem_req  = memop;
         mem_stall = memop & ~dmem_ready;
         done      = ex_valid & (~memop | dmem_ready);
      end
      dmem_addr  = {cur_alu[15:1], 1'b0};
      dmem_wdata = cur_wdata;
      dmem_we    = cur_we;
      wb_data_d  = cur_rd ? dmem_rdata : cur_alu;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         wait_cnt_q     <= '0;
         alu_q          <= '0;
         wdata_q        <= '0;
         we_q           <= 1'b0;
         rd_q           <= 1'b0;
         rw_q           <= 1'b0;
         halt_q         <= 1'b0;
         dst_q          <= '0;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_halt_q      <= 1'b0;
         wb_data_q      <= '0;
         wb_dst_q       <= '0;
         mem_error_q    <= 1'b0;
      end else begin
         wb_valid_q     <= done;
         wb_reg_write_q <= done & cur_rw;
         wb_halt_q      <= done & cur_halt;
         if (done) begin
            wb_data_q <= wb_data_d;
            wb_dst_q  <= cur_dst;
         end
         if (state_q == IDLE) begin
            if (memop && !dmem_ready) begin
               state_q    <= BUSY;
               wait_cnt_q <= WAIT_W'(1);
               alu_q      <= alu_result;
               wdata_q    <= store_data;
               we_q       <= mem_write;
               rd_q       <= mem_read & ~mem_write;
               rw_q       <= reg_write;
               halt_q     <= halt;
               dst_q      <= dst_reg;
            end
         end else begin
            if (dmem_ready) begin
               state_q    <= IDLE;
               wait_cnt_q <= '0;
            end else begin
               if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
               // timeout only flags; the access keeps waiting
               if (MAX_WAIT != 0 && wait_cnt_q == MAX_C) mem_error_q <= 1'b1;
            end
         end
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_data      = wb_data_q;
   assign wb_dst       = wb_dst_q;
   assign wb_reg_write = wb_reg_write_q;
   assign wb_halt      = wb_halt_q;
   assign mem_error    = mem_error_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus hand sequences
// for wait states, timeout, mid-access reset and back-to-back ops.
module tb_memory_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, mem_read, mem_write, reg_write, halt, dmem_ready;
   logic [15:0] alu_result, store_data, dmem_rdata;
   logic [3:0]  dst_reg;
   logic        dmem_req, dmem_we, mem_stall, wb_valid, wb_reg_write, wb_halt, mem_error;
   logic [15:0] dmem_addr, dmem_wdata, wb_data;
   logic [3:0]  wb_dst;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   memory_stage #(.MAX_WAIT(4), .WAIT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result(alu_result),
      .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .dst_reg(dst_reg), .halt(halt),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst(wb_dst),
      .wb_reg_write(wb_reg_write), .wb_halt(wb_halt), .mem_error(mem_error));

   typedef struct {
      logic        ev, rd, wr, rw, hlt, rdy;
      logic [15:0] alu, sd, rdata;
      logic [3:0]  dst;
      logic        x_req, x_we, x_stall;
      logic [15:0] x_addr, x_wdata;
      logic        x_wbv, x_wbrw, x_wbh;
      logic [15:0] x_wbd;
      logic [3:0]  x_wbdst;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ex_valid = 0; mem_read = 0; mem_write = 0; reg_write = 0; halt = 0;
      alu_result = 0; store_data = 0; dst_reg = 0; dmem_rdata = 0; dmem_ready = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic ev, rd, wr, rw, hlt, rdy,
                               input logic [15:0] alu, sd, rdata, input logic [3:0] dst,
                               input logic xreq, xwe, xstall, input logic [15:0] xaddr,
                               input logic xwbv, xwbrw, xwbh, input logic [15:0] xwbd,
                               input logic [3:0] xwbdst);
      vec_t v;
      v.ev = ev; v.rd = rd; v.wr = wr; v.rw = rw; v.hlt = hlt; v.rdy = rdy;
      v.alu = alu; v.sd = sd; v.rdata = rdata; v.dst = dst;
      v.x_req = xreq; v.x_we = xwe; v.x_stall = xstall; v.x_addr = xaddr; v.x_wdata = sd;
      v.x_wbv = xwbv; v.x_wbrw = xwbrw; v.x_wbh = xwbh; v.x_wbd = xwbd; v.x_wbdst = xwbdst;
      return v;
   endfunction

   initial begin
      //             ev rd wr rw h rdy alu      sd       rdata    dst   req we st addr     wbv rw h  wbd      dst
      vecs[0] = mk(1, 0, 0, 1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 4'd3, 0, 0, 0, 16'h1234, 1, 1, 0, 16'h1234, 4'd3);
      vecs[1] = mk(0, 0, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 4'd9, 0, 0, 0, 16'hFFFE, 0, 0, 0, 16'h1234, 4'd3);
      vecs[2] = mk(1, 1, 0, 1, 0, 1, 16'h0041, 16'h0000, 16'hBEEF, 4'd5, 1, 0, 0, 16'h0040, 1, 1, 0, 16'hBEEF, 4'd5);
      vecs[3] = mk(1, 0, 1, 0, 0, 1, 16'h0203, 16'h5A5A, 16'h1111, 4'd2, 1, 1, 0, 16'h0202, 1, 0, 0, 16'h0203, 4'd2);
      vecs[4] = mk(1, 1, 1, 1, 0, 1, 16'h0300, 16'h0077, 16'h9999, 4'd7, 1, 1, 0, 16'h0300, 1, 1, 0, 16'h0300, 4'd7);
      vecs[5] = mk(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 4'd0);
      vecs[6] = mk(0, 1, 0, 1, 0, 0, 16'h0008, 16'h0000, 16'h0000, 4'd1, 0, 0, 0, 16'h0008, 0, 0, 0, 16'h0000, 4'd0);

      idle_inputs();
      rst_n = 0;
      #12;
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      chk("rst_mem_error", 32'(mem_error), 32'd0);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_mem_stall", 32'(mem_stall), 32'd0);
      rst_n = 1;
      tick();

      // single-cycle vectors
      for (int i = 0; i < 7; i++) begin
         ex_valid = vecs[i].ev; mem_read = vecs[i].rd; mem_write = vecs[i].wr;
         reg_write = vecs[i].rw; halt = vecs[i].hlt; dmem_ready = vecs[i].rdy;
         alu_result = vecs[i].alu; store_data = vecs[i].sd; dmem_rdata = vecs[i].rdata;
         dst_reg = vecs[i].dst;
         #1;
         chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].x_req));
         chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'(vecs[i].x_stall));
         chk($sformatf("v%0d_addr", i), 32'(dmem_addr), 32'(vecs[i].x_addr));
         if (vecs[i].x_req) begin
            chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].x_we));
            chk($sformatf("v%0d_wdata", i), 32'(dmem_wdata), 32'(vecs[i].x_wdata));
         end
         tick();
         chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].x_wbv));
         chk($sformatf("v%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].x_wbd));
         chk($sformatf("v%0d_wb_dst", i), 32'(wb_dst), 32'(vecs[i].x_wbdst));
         chk($sformatf("v%0d_wb_rw", i), 32'(wb_reg_write), 32'(vecs[i].x_wbrw));
         chk($sformatf("v%0d_wb_halt", i), 32'(wb_halt), 32'(vecs[i].x_wbh));
      end
      idle_inputs();
      tick();

      // 3-wait store with upstream inputs disturbed during the wait
      begin
         int stalls;
         stalls = 0;
         ex_valid = 1; mem_write = 1; reg_write = 0; alu_result = 16'h0100;
         store_data = 16'hA5A5; dst_reg = 4'd4; dmem_ready = 0;
         #1;
         stalls += int'(mem_stall);
         tick();
         alu_result = 16'hFFFF; store_data = 16'h0000; mem_write = 0; mem_read = 1; reg_write = 1;
         for (int c = 0; c < 3; c++) begin
            if (c == 2) dmem_ready = 1;
            #1;
            stalls += int'(mem_stall);
            chk($sformatf("st_req_c%0d", c), 32'(dmem_req), 32'd1);
            chk($sformatf("st_addr_c%0d", c), 32'(dmem_addr), 32'h0100);
            chk($sformatf("st_wdata_c%0d", c), 32'(dmem_wdata), 32'hA5A5);
            chk($sformatf("st_we_c%0d", c), 32'(dmem_we), 32'd1);
            chk($sformatf("st_wbv_c%0d", c), 32'(wb_valid), 32'd0);
            tick();
         end
         chk("st_stall_count", 32'(stalls), 32'd3);
         chk("st_wb_valid", 32'(wb_valid), 32'd1);
         chk("st_wb_rw", 32'(wb_reg_write), 32'd0);
         chk("st_wb_dst", 32'(wb_dst), 32'd4);
         chk("st_wb_data", 32'(wb_data), 32'h0100);
         idle_inputs();
         tick();
      end

      // back-to-back: 2-wait load then ALU op
      ex_valid = 1; mem_read = 1; reg_write = 1; alu_result = 16'h0010; dst_reg = 4'd6;
      #1;
      chk("bb_stall0", 32'(mem_stall), 32'd1);
      tick();
      #1;
      chk("bb_stall1", 32'(mem_stall), 32'd1);
      tick();
      dmem_ready = 1; dmem_rdata = 16'h00FF;
      #1;
      chk("bb_stall2", 32'(mem_stall), 32'd0);
      tick();
      chk("bb_wb1_valid", 32'(wb_valid), 32'd1);
      chk("bb_wb1_data", 32'(wb_data), 32'h00FF);
      chk("bb_wb1_dst", 32'(wb_dst), 32'd6);
      mem_read = 0; dmem_ready = 0; alu_result = 16'h0007; dst_reg = 4'd8;
      #1;
      chk("bb_alu_stall", 32'(mem_stall), 32'd0);
      tick();
      chk("bb_wb2_valid", 32'(wb_valid), 32'd1);
      chk("bb_wb2_data", 32'(wb_data), 32'h0007);
      chk("bb_wb2_dst", 32'(wb_dst), 32'd8);
      idle_inputs();
      tick();
      chk("bb_no_dup", 32'(wb_valid), 32'd0);

      // timeout with MAX_WAIT=4
      ex_valid = 1; mem_read = 1; reg_write = 1; alu_result = 16'h0500; dst_reg = 4'd10;
      tick();
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("to_err_busy%0d", c), 32'(mem_error), 32'd0);
         tick();
      end
      chk("to_err_set", 32'(mem_error), 32'd1);
      chk("to_still_stall", 32'(mem_stall), 32'd1);
      dmem_ready = 1; dmem_rdata = 16'hCAFE;
      tick();
      chk("to_err_sticky", 32'(mem_error), 32'd1);
      chk("to_wb_valid", 32'(wb_valid), 32'd1);
      chk("to_wb_data", 32'(wb_data), 32'hCAFE);
      idle_inputs();
      tick();
      chk("to_err_sticky2", 32'(mem_error), 32'd1);

      // reset in the middle of a stalled load
      ex_valid = 1; mem_read = 1; reg_write = 1; alu_result = 16'h0600; dst_reg = 4'd2;
      tick();
      tick();
      chk("rb_busy_req", 32'(dmem_req), 32'd1);
      #2;
      idle_inputs();
      rst_n = 0;
      #1;
      chk("rb_req", 32'(dmem_req), 32'd0);
      chk("rb_stall", 32'(mem_stall), 32'd0);
      chk("rb_wb_valid", 32'(wb_valid), 32'd0);
      chk("rb_err", 32'(mem_error), 32'd0);
      tick();
      rst_n = 1;
      tick();
      ex_valid = 1; reg_write = 1; alu_result = 16'h4321; dst_reg = 4'd11;
      #1;
      chk("rb_after_req", 32'(dmem_req), 32'd0);
      tick();
      chk("rb_after_wbv", 32'(wb_valid), 32'd1);
      chk("rb_after_wbd", 32'(wb_data), 32'h4321);
      chk("rb_after_dst", 32'(wb_dst), 32'd11);
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
